// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-op arbiter: opcodes, FSM states and the
// per-bit evaluation of the opcode table.
package logic_op_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOTA = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic err;
    logic res;
  } lo_bit_t;

  // Every opcode is bitwise, so one bit position fully describes the op;
  // callers replicate it across any operand width.
  function automatic lo_bit_t lo_eval(input logic [2:0] op, input logic a, input logic b);
    lo_bit_t r;
    r.err = 1'b0;
    r.res = 1'b0;
    case (op)
      OP_AND:  r.res = a & b;
      OP_OR:   r.res = a | b;
      OP_NOTA: r.res = ~a;
      OP_NAND: r.res = ~(a & b);
      OP_NOR:  r.res = ~(a | b);
      OP_XOR:  r.res = a ^ b;
      OP_XNOR: r.res = ~(a ^ b);
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_arbiter_if.sv
// Request/response bus between the requesters and the shared logic-op arbiter.
interface logic_op_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/logic_op_unit.sv
// Combinational bitwise logic-op datapath, W bits wide.
module logic_op_unit
  import logic_op_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         err
);

  lo_bit_t r;

  always_comb begin
    res = '0;
    err = 1'b0;
    r   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      r      = lo_eval(op, a[i], b[i]);
      res[i] = r.res;
      err    = r.err;
    end
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic-op unit among NREQ requesters, with a
// registered, tagged response held until the consumer accepts it.
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned IDW  = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_op_arbiter_if.slave    bus,
  output logic                 busy,
  output logic [CNTW-1:0]      ops_done
);

  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [CNTW-1:0] ops_done_q, ops_done_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    cand_sum;
  logic [IDW-1:0]  cand;
  logic [2:0]      op_sel;
  logic [W-1:0]    a_sel, b_sel;
  logic [W-1:0]    unit_res;
  logic            unit_err;

  // Wrap search from rr_ptr; the first valid requester found wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand_sum >= NREQ_W) cand_sum = cand_sum - NREQ_W;
      cand = cand_sum[IDW-1:0];
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_idx) begin
        op_sel = bus.req_op[3*i +: 3];
        a_sel  = bus.req_a[W*i +: W];
        b_sel  = bus.req_b[W*i +: W];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == S_IDLE && grant_found) bus.req_ready[grant_idx] = 1'b1;
  end

  logic_op_unit #(.W(W)) u_unit (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (unit_res),
    .err (unit_err)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    ops_done_d  = ops_done_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          op_d    = op_sel;
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = grant_idx;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_data_d  = unit_res;
        rsp_err_d   = unit_err;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + CNTW'(1);
          rr_ptr_d    = (rsp_id_q == LAST_ID) ? '0 : rsp_id_q + IDW'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != S_IDLE);
  assign ops_done      = ops_done_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: directed sequences, an opcode
// table and randomized traffic checked against a behavioural model.
module tb_logic_op_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned IDW  = 2;
  localparam int unsigned CNTW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            busy;
  logic [CNTW-1:0] ops_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic_op_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  logic_op_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_d;
    logic       exp_e;
  } vec_t;

  vec_t vecs[8];

  // Opcode semantics straight from the opcode table: {err, result}.
  function automatic logic [8:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, ~a};
      3'd3:    return {1'b0, ~(a & b)};
      3'd4:    return {1'b0, ~(a | b)};
      3'd5:    return {1'b0, a ^ b};
      3'd6:    return {1'b0, ~(a ^ b)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  function automatic int ref_grant(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_op[3*i +: 3] = op;
    bus.req_a[8*i +: 8]  = a;
    bus.req_b[8*i +: 8]  = b;
  endtask

  // Presents one request, waits for its grant, and leaves the bench at the
  // falling edge of the EXEC cycle with req_valid dropped.
  task automatic issue(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output bit ok);
    set_req(i, op, a, b);
    bus.req_valid[i] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      timeout_fail("grant_wait");
      bus.req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[i] = 1'b0;
    #1;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) timeout_fail("rsp_wait");
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    logic [1:0] s_id;
    logic [7:0] s_data;
    logic       s_err;
    logic [2:0] t_op[4];
    logic [7:0] t_a[4];
    logic [7:0] t_b[4];
    int         exp_order[5];
    int         ng;
    int         nr;
    int         mrr;
    int         mcnt;
    int         g;
    logic [3:0] mask;
    logic [8:0] expv;

    vecs[0] = '{3'b000, 8'hAA, 8'h0F, 8'h0A, 1'b0};
    vecs[1] = '{3'b001, 8'hAA, 8'h0F, 8'hAF, 1'b0};
    vecs[2] = '{3'b010, 8'hAA, 8'h0F, 8'h55, 1'b0};
    vecs[3] = '{3'b011, 8'hAA, 8'h0F, 8'hF5, 1'b0};
    vecs[4] = '{3'b100, 8'hAA, 8'h0F, 8'h50, 1'b0};
    vecs[5] = '{3'b101, 8'hAA, 8'h0F, 8'hA5, 1'b0};
    vecs[6] = '{3'b110, 8'hAA, 8'h0F, 8'h5A, 1'b0};
    vecs[7] = '{3'b111, 8'hAA, 8'h0F, 8'h00, 1'b1};

    // Reset state and the single-request latency sequence.
    do_reset();
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_id", bus.rsp_id, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_rsp_err", bus.rsp_err, 0);
    check("reset_busy", busy, 0);
    check("reset_ops_done", ops_done, 0);
    check("reset_req_ready", bus.req_ready, 0);

    set_req(2, 3'b000, 8'hF0, 8'h3C);
    bus.req_valid[2] = 1'b1;
    #1;
    check("t1_req_ready", bus.req_ready, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    #1;
    check("t1_exec_no_rsp", bus.rsp_valid, 0);
    check("t1_exec_busy", busy, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t1_rsp_valid", bus.rsp_valid, 1);
    check("t1_rsp_id", bus.rsp_id, 2);
    check("t1_rsp_data", bus.rsp_data, 8'h30);
    check("t1_rsp_err", bus.rsp_err, 0);
    finish_rsp();
    check("t1_ops_done", ops_done, 1);
    check("t1_rsp_cleared", bus.rsp_valid, 0);
    check("t1_idle", busy, 0);

    // Opcode table sweep.
    do_reset();
    for (int v = 0; v < 8; v++) begin
      issue(1, vecs[v].op, vecs[v].a, vecs[v].b, ok);
      if (ok) wait_rsp(ok);
      if (ok) begin
        check("t2_data", bus.rsp_data, vecs[v].exp_d);
        check("t2_err", bus.rsp_err, vecs[v].exp_e);
        check("t2_id", bus.rsp_id, 1);
        finish_rsp();
      end
    end
    check("t2_ops_done", ops_done, 8);

    // All requesters asserting: round-robin order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      t_op[i] = 3'(i);
      t_a[i]  = 8'h5A + 8'(i * 17);
      t_b[i]  = 8'hC3 ^ 8'(i);
      set_req(i, t_op[i], t_a[i], t_b[i]);
    end
    exp_order = '{0, 1, 2, 3, 0};
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    #1;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 40 && (ng < 5 || nr < 5); c++) begin
      if (bus.req_ready != 0 && ng < 5) begin
        check("t3_grant", bus.req_ready, 64'(1) << exp_order[ng]);
        ng++;
      end
      if (bus.rsp_valid && nr < 5) begin
        expv = ref_op(t_op[exp_order[nr]], t_a[exp_order[nr]], t_b[exp_order[nr]]);
        check("t3_rsp_id", bus.rsp_id, exp_order[nr]);
        check("t3_rsp_data", bus.rsp_data, expv[7:0]);
        nr++;
      end
      @(negedge clk);
      #1;
    end
    if (ng < 5 || nr < 5) timeout_fail("t3_rr_sequence");
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;

    // Backpressure: response held stable while rsp_ready is low.
    do_reset();
    issue(3, 3'b101, 8'h96, 8'h3C, ok);
    if (ok) wait_rsp(ok);
    if (ok) begin
      set_req(0, 3'b000, 8'hFF, 8'hFF);
      bus.req_valid[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
        #1;
        check("t4_hold_valid", bus.rsp_valid, 1);
        check("t4_hold_id", bus.rsp_id, 3);
        check("t4_hold_data", bus.rsp_data, 8'hAA);
        check("t4_hold_err", bus.rsp_err, 0);
        check("t4_no_ready", bus.req_ready, 0);
        check("t4_busy", busy, 1);
        @(negedge clk);
      end
      bus.req_valid[0] = 1'b0;
      finish_rsp();
      check("t4_done_valid", bus.rsp_valid, 0);
      check("t4_ops_done", ops_done, 1);
    end

    // Operand change after the handshake must not affect the result.
    do_reset();
    issue(1, 3'b001, 8'h11, 8'h22, ok);
    if (ok) begin
      bus.req_a[8 +: 8] = 8'hFF;
      wait_rsp(ok);
      if (ok) begin
        check("t5_data", bus.rsp_data, 8'h33);
        finish_rsp();
      end
    end

    // Reset during EXEC aborts the op and clears the counter.
    do_reset();
    issue(0, 3'b000, 8'h0F, 8'hFF, ok);
    if (ok) wait_rsp(ok);
    if (ok) finish_rsp();
    check("t6_pre_ops", ops_done, 1);
    issue(2, 3'b101, 8'h12, 8'h34, ok);
    if (ok) begin
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", busy, 0);
      check("t6_rst_valid", bus.rsp_valid, 0);
      check("t6_rst_ops", ops_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        #1;
        check("t6_no_rsp", bus.rsp_valid, 0);
      end
      check("t6_idle", busy, 0);
      check("t6_ops_after", ops_done, 0);
    end

    // Randomized traffic against the behavioural model.
    do_reset();
    mrr  = 0;
    mcnt = 0;
    for (int t = 0; t < 60; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        t_op[i] = 3'($urandom_range(0, 7));
        t_a[i]  = 8'($urandom);
        t_b[i]  = 8'($urandom);
        set_req(i, t_op[i], t_a[i], t_b[i]);
      end
      bus.req_valid = mask;
      #1;
      g = ref_grant(mask, mrr);
      check("rand_grant", bus.req_ready, 64'(1) << g);
      expv = ref_op(t_op[g], t_a[g], t_b[g]);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = '0;
      bus.req_a     = W*NREQ'($urandom);
      bus.req_op    = 3*NREQ'($urandom);
      #1;
      wait_rsp(ok);
      if (!ok) break;
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
        @(negedge clk);
        #1;
        check("rand_stall_valid", bus.rsp_valid, 1);
      end
      check("rand_id", bus.rsp_id, g);
      check("rand_data", bus.rsp_data, expv[7:0]);
      check("rand_err", bus.rsp_err, expv[8]);
      finish_rsp();
      mcnt++;
      check("rand_ops_done", ops_done, mcnt);
      mrr = (g + 1) % 4;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one bitwise logic-op unit among NREQ requesters using round-robin arbitration.
- Each requester presents an opcode and two operands with a valid/ready handshake.
- The block grants one requester, executes the op, and returns a tagged, registered response with backpressure.
- It sits between requester blocks and the shared combinational logic-op datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand/result width in bits.
- IDW, 2, requester-id width; must equal clog2(NREQ).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_op  in  3*NREQ  opcode for requester i at [3i+:3].
- req_a  in  W*NREQ  operand A for requester i at [Wi+:W].
- req_b  in  W*NREQ  operand B for requester i at [Wi+:W].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  id of the requester that owns the response.
- rsp_data  out  W  result.
- rsp_err  out  1  illegal opcode flag.
- busy  out  1  high when state is not IDLE.
- ops_done  out  CNTW  count of completed responses.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - State = IDLE, rr_ptr = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0.
  - ops_done = 0, busy = 0, all captured operand registers = 0.
- Opcodes (bitwise over W bits):
  - 000 = a&b, 001 = a|b, 010 = ~a, 011 = ~(a&b).
  - 100 = ~(a|b), 101 = a^b, 110 = ~(a^b).
  - 111 = illegal: result 0, rsp_err = 1. Every legal opcode gives rsp_err = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid high, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready is combinational, one-hot on the granted index; all zero if no valid or if not in IDLE.
  - On a handshake edge: capture op/a/b and the id, then go to EXEC.
- EXEC: compute from the captured registers. At the next edge, load rsp_data/rsp_err/rsp_id, set rsp_valid = 1, go to RESP.
- RESP:
  - rsp_valid and all rsp_* are held stable until rsp_ready = 1.
  - On that edge: rsp_valid = 0, ops_done += 1 (wraps at 2^CNTW), rr_ptr = (rsp_id+1) mod NREQ, go to IDLE.
- Latency and throughput:
  - Accept edge T; rsp_valid rises at edge T+1.
  - With rsp_ready held high, one operation per 3 cycles.
- Fairness: a continuously asserting requester waits at most NREQ-1 other grants.
- Requester inputs are sampled only in the IDLE handshake cycle. Changes afterwards do not affect an in-flight op.
- Deasserting req_valid before a grant is legal; that request is simply not served.
- Simultaneous valids are resolved by rr_ptr only. Index priority applies only through the wrap search.
- Reset asserted mid-operation aborts the op immediately: state IDLE, rsp_valid 0, counter cleared, no response emitted.
- busy = (state != IDLE).

Decomposition:
- Package logic_op_pkg holds:
  - the opcode localparams (OP_AND..OP_XNOR, OP_ILL = 3'b111);
  - the state encoding (S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2);
  - a function that computes the result and error flag from op, a, b.
- One sub-module, logic_op_unit: purely combinational, W-parameterised, implementing the opcode table. It is instanced once in logic_op_arbiter.
- The round-robin search stays in the top level.

Test Plan:
1. Reset, then req_valid[2] = 1, op = 000, a = 8'hF0, b = 8'h3C. Required: req_ready = 4'b0100 that cycle; after 2 cycles rsp_valid = 1, rsp_id = 2, rsp_data = 8'h30, rsp_err = 0; ops_done = 1 after the rsp_ready handshake.
2. Sweep all ops with a = 8'hAA, b = 8'h0F. Required rsp_data: 0A, AF, 55, F5, 50, A5, 5A; op 111 gives 00 with rsp_err = 1.
3. All four req_valid held high from reset, rsp_ready = 1. Required grant order: 0, 1, 2, 3, 0, with each rsp_id matching.
4. Hold rsp_ready = 0 for 5 cycles in RESP. Required: rsp_* stable, req_ready = 0, busy = 1; the response completes on the first rsp_ready = 1 edge.
5. Change req_a from 8'h11 to 8'hFF during EXEC. Required: the result uses 8'h11.
6. Assert rst_n = 0 in EXEC, then release. Required: rsp_valid never rises for the aborted op; ops_done = 0 and state = IDLE.
